dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 58 +++++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, bus widths and the address range check.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when no address bit above the word index and byte offset is set.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> (addr_w + 32'd2)) == 32'd0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// On a write, the read register captures the merged word, so the response shows the post-write contents.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_we,
    input  logic                i_zero,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [WORD_W-1:0]   i_wdata,
    input  logic [MASK_W-1:0]   i_mask,
    output logic [WORD_W-1:0]   o_rdata
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;
    logic [WORD_W-1:0] w_merged;
    logic              w_wr;

    assign w_wr = i_en && i_we && !i_zero && !rst;

    always_comb begin
        w_merged = r_mem[i_addr];
        if (i_we) begin
            for (int b = 0; b < int'(MASK_W); b++) begin
                if (i_mask[b]) begin
                    w_merged[8*b +: 8] = i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Memory contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(MASK_W); b++) begin
            if (w_wr && i_mask[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= i_zero ? '0 : w_merged;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, LATENCY wait states, then a held response.
// Sits between the load/store wrapper and the memory array in stalling-core mode.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [WORD_W-1:0]   req_wdata,
    input  logic [MASK_W-1:0]   req_mask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORD_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LAT_W-1:0]   r_cnt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [WORD_W-1:0]  r_wdata;
    logic [MASK_W-1:0]  r_mask;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic               w_accept;
    logic               w_exec;
    logic               w_in_range;
    logic [WORD_W-1:0]  w_rdata;

    assign w_in_range = addr_in_range(r_addr, ADDR_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // LATENCY=0 still passes through WAIT once, which is the single pending step before RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_exec      = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_mask  <= req_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= LAT_W'(LATENCY);
        end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - LAT_W'(1);
        end
    end

    // Handshake flags follow the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            if (w_exec) begin
                r_rsp_err <= !w_in_range;
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_exec),
        .i_we    (r_we),
        .i_zero  (!w_in_range),
        .i_addr  (r_addr[ADDR_W+1:2]),
        .i_wdata (r_wdata),
        .i_mask  (r_mask),
        .o_rdata (w_rdata)
    );

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = w_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a transaction-level reference model checked every cycle,
// plus directed transactions with hand-computed expectations (LATENCY=2 and LATENCY=0 instances).
module tb_dmem_responder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned LAT    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_mask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_we0;
    logic [31:0] req_addr0, req_wdata0;
    logic [3:0]  req_mask0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_mask(req_mask0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one request in flight, response due LAT+1 edges after acceptance.
    logic [31:0] m_mem [256];
    bit          m_live = 0;
    bit          m_busy = 0;
    bit          m_rsp = 0;
    bit          m_after_rst = 1;
    int          m_due = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    logic [31:0] m_rdata = 32'h0;
    logic        m_err = 1'b0;
    bit          m_ready_now;

    always @(posedge clk) begin
        m_ready_now = !m_busy && !m_after_rst;
        if (rst) begin
            m_live      = 1;
            m_busy      = 0;
            m_rsp       = 0;
            m_after_rst = 1;
            m_rdata     = 32'h0;
            m_err       = 1'b0;
        end else begin
            m_after_rst = 0;
            if (m_rsp) begin
                if (rsp_ready) begin
                    m_rsp  = 0;
                    m_busy = 0;
                end
            end else if (m_busy) begin
                m_due = m_due - 1;
                if (m_due == 0) begin
                    if (m_addr >= (32'd1 << (ADDR_W + 2))) begin
                        m_rdata = 32'h0;
                        m_err   = 1'b1;
                    end else begin
                        int w;
                        w = int'(m_addr >> 2);
                        if (m_we) begin
                            for (int b = 0; b < 4; b++) begin
                                if (m_mask[b]) m_mem[w][8*b +: 8] = m_wdata[8*b +: 8];
                            end
                        end
                        m_rdata = m_mem[w];
                        m_err   = 1'b0;
                    end
                    m_rsp = 1;
                end
            end else if (m_ready_now && req_valid) begin
                m_busy  = 1;
                m_due   = int'(LAT) + 1;
                m_we    = req_we;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_mask  = req_mask;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_after_rst));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            chk("valid_ready_exclusive", 32'(rsp_valid & req_ready), 32'h0);
            if (m_rsp) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    // Waits for acceptance; on return we are #1 after the acceptance edge with garbage on req_*.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input string name);
        int n;
        req_we = we; req_addr = addr; req_wdata = wdata; req_mask = mask; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_accept_timeout"}, 32'(n >= 50), 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_mask = ~mask;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err, input string name);
        int n;
        rsp_ready = (hold == 0);
        issue(we, addr, wdata, mask, name);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'd3);
        chk({name, "_rdata"}, rsp_rdata, exp_rdata);
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, 32'(rsp_valid), 32'h1);
            chk({name, "_hold_rdata"}, rsp_rdata, exp_rdata);
            chk({name, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
            chk({name, "_hold_ready"}, 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_done_valid"}, 32'(rsp_valid), 32'h0);
        chk({name, "_done_ready"}, 32'(req_ready), 32'h1);
    endtask

    // Accept a store, then pulse reset rst_delay cycles later; no response may appear.
    task automatic txn_abort(input logic [31:0] addr, input logic [31:0] wdata,
                             input int rst_delay, input string name);
        int seen;
        rsp_ready = 1'b1;
        issue(1'b1, addr, wdata, 4'hF, name);
        for (int i = 0; i < rst_delay; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({name, "_rst_valid"}, 32'(rsp_valid), 32'h0);
        chk({name, "_rst_ready"}, 32'(req_ready), 32'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen++;
        end
        chk({name, "_no_rsp"}, 32'(seen), 32'h0);
        chk({name, "_idle_ready"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_mask = 4'h0;
        rsp_ready = 1'b1;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0; req_mask0 = 4'h0;
        rsp_ready0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'h0);
        chk("reset_rsp_valid0", 32'(rsp_valid0), 32'h0);
        rst = 1'b0;

        txn(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 0, 32'h0BAD_F00D, 1'b0, "pre_w0");
        txn(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0, 32'h1234_5678, 1'b0, "pre_w20");
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, "st_full");
        txn(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0, "ld_full");
        txn(1'b1, 32'h0000_0010, 32'h00AA_0000, 4'b0100, 0, 32'hDEAA_BEEF, 1'b0, "st_byte2");
        txn(1'b0, 32'h0000_0013, 32'h0,         4'hF, 0, 32'hDEAA_BEEF, 1'b0, "ld_byte2");
        txn(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 0, 32'hDEAA_BEEF, 1'b0, "st_mask0");
        txn(1'b0, 32'h0000_0010, 32'h0,         4'h0, 5, 32'hDEAA_BEEF, 1'b0, "ld_backpr");
        txn(1'b0, 32'h0000_0400, 32'h0,         4'h0, 0, 32'h0,         1'b1, "ld_oor");
        txn(1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 2, 32'h0,         1'b1, "st_oor");
        txn(1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'h0BAD_F00D, 1'b0, "ld_w0_after_oor");
        txn(1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'h0,         1'b1, "ld_oor_high");
        txn_abort(32'h0000_0020, 32'hCAFE_F00D, 0, "abort_wait");
        txn(1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 32'h1234_5678, 1'b0, "ld_after_abort");
        txn_abort(32'h0000_0020, 32'hCAFE_F00D, 2, "abort_exec");
        txn(1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 32'h1234_5678, 1'b0, "ld_after_exec_rst");

        // LATENCY=0 instance: response one edge after acceptance; held valid waits for handshake.
        req_we0 = 1'b1; req_addr0 = 32'h0000_0008; req_wdata0 = 32'h1122_3344; req_mask0 = 4'hF;
        rsp_ready0 = 1'b0;
        req_valid0 = 1'b1;
        n = 0;
        while (req_ready0 !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("l0_accept_timeout", 32'(n >= 50), 32'h0);
        @(posedge clk); #1;
        chk("l0_T_valid", 32'(rsp_valid0), 32'h0);
        chk("l0_T_ready", 32'(req_ready0), 32'h0);
        req_we0 = 1'b0; req_addr0 = 32'h0000_0008; req_wdata0 = 32'h0; req_mask0 = 4'h0;
        @(posedge clk); #1;
        chk("l0_T1_valid", 32'(rsp_valid0), 32'h1);
        chk("l0_T1_rdata", rsp_rdata0, 32'h1122_3344);
        chk("l0_T1_err", 32'(rsp_err0), 32'h0);
        chk("l0_T1_ready", 32'(req_ready0), 32'h0);
        @(posedge clk); #1;
        chk("l0_T2_valid", 32'(rsp_valid0), 32'h1);
        chk("l0_T2_ready", 32'(req_ready0), 32'h0);
        rsp_ready0 = 1'b1;
        @(posedge clk); #1;
        chk("l0_T3_valid", 32'(rsp_valid0), 32'h0);
        chk("l0_T3_ready", 32'(req_ready0), 32'h1);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        chk("l0_T4_valid", 32'(rsp_valid0), 32'h0);
        chk("l0_T4_ready", 32'(req_ready0), 32'h0);
        @(posedge clk); #1;
        chk("l0_T5_valid", 32'(rsp_valid0), 32'h1);
        chk("l0_T5_rdata", rsp_rdata0, 32'h1122_3344);
        @(posedge clk); #1;
        chk("l0_T6_valid", 32'(rsp_valid0), 32'h0);
        chk("l0_T6_ready", 32'(req_ready0), 32'h1);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
